// File: rtl/rstint_dispatch.sv
// rstint_dispatch: queues decoded interrupt packets and presents them one at a time to the thread FSM.
// Latency: 1 cycle from pkt_vld to outputs when idle (FIFO bypass); back-to-back presentation on thr_ack.
// Backpressure: pkt_rdy low when FIFO full and no dequeue this cycle; valid packets then dropped, ovfl set.
// Optional RSTINT_COALESCE_EN: drop packets duplicating a queued or presented {type,tid}.
module rstint_dispatch #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pkt_vld,
  input  logic [1:0]    pkt_type,
  input  logic [1:0]    pkt_tid,
  output logic          pkt_rdy,
  input  logic          thr_ack,
  output logic          rstint,
  output logic          nukeint,
  output logic          resumint,
  output logic [3:0]    rstthr,
  output logic [AW:0]   fifo_cnt,
  output logic          ovfl,
  input  logic          ovfl_clr
);

  typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

  state_t        state;
  logic [1:0]    mem_type [DEPTH];
  logic [1:0]    mem_tid  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          fifo_empty;
  logic          fifo_full;
  logic          slot_free;
  logic          deq;
  logic          pkt_real;
  logic          dup;
  logic          enq_ok;
  logic          bypass;
  logic          push;
  logic          drop;
  logic [1:0]    sel_type;
  logic [1:0]    sel_tid;

  // Dequeue / enqueue / bypass decisions for this cycle
  always_comb begin
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));
    // Output stage can take a new entry: empty, or the presented one is being acked
    slot_free  = (state == ST_IDLE) | thr_ack;
    deq        = slot_free & ~fifo_empty;
    pkt_rdy    = ~fifo_full | deq;
    pkt_real   = pkt_vld & (pkt_type != 2'b00);
    enq_ok     = pkt_real & pkt_rdy & ~dup;
    bypass     = enq_ok & slot_free & fifo_empty;
    push       = enq_ok & ~bypass;
    drop       = pkt_real & ~pkt_rdy & ~dup;
    sel_type   = deq ? mem_type[rd_ptr] : pkt_type;
    sel_tid    = deq ? mem_tid[rd_ptr]  : pkt_tid;
  end

`ifdef RSTINT_COALESCE_EN
  logic [AW-1:0] scan_idx;
  logic [1:0]    cur_type;
  logic [1:0]    cur_tid;

  // Duplicate detection against the pre-dequeue queue contents and the presented entry
  always_comb begin
    dup      = 1'b0;
    scan_idx = '0;
    cur_type = {nukeint | resumint, rstint | resumint};
    cur_tid  = {rstthr[3] | rstthr[2], rstthr[3] | rstthr[1]};
    if ((state == ST_PRESENT) && (cur_type == pkt_type) && (cur_tid == pkt_tid))
      dup = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + AW'(k);
      if (((AW+1)'(k) < fifo_cnt) && (mem_type[scan_idx] == pkt_type) &&
          (mem_tid[scan_idx] == pkt_tid))
        dup = 1'b1;
    end
  end
`else
  // Duplicates are queued like any other packet
  always_comb begin
    dup = 1'b0;
  end
`endif

  // FIFO storage, pointers and occupancy (occupancy excludes the presented entry)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_type[wr_ptr] <= pkt_type;
        mem_tid[wr_ptr]  <= pkt_tid;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, deq})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Output stage FSM with registered interrupt level outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rstint   <= 1'b0;
      nukeint  <= 1'b0;
      resumint <= 1'b0;
      rstthr   <= 4'b0000;
    end else if (deq | bypass) begin
      state    <= ST_PRESENT;
      rstint   <= (sel_type == 2'b01);
      nukeint  <= (sel_type == 2'b10);
      resumint <= (sel_type == 2'b11);
      rstthr   <= 4'b0001 << sel_tid;
    end else if (slot_free) begin
      state    <= ST_IDLE;
      rstint   <= 1'b0;
      nukeint  <= 1'b0;
      resumint <= 1'b0;
      rstthr   <= 4'b0000;
    end
  end

  // Sticky overflow flag; a new drop wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset)
      ovfl <= 1'b0;
    else if (drop)
      ovfl <= 1'b1;
    else if (ovfl_clr)
      ovfl <= 1'b0;
  end

endmodule

// File: tb/tb_rstint_dispatch.sv
// Bench for rstint_dispatch: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the dispatcher.
module tb_rstint_dispatch;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          reset;
  logic          pkt_vld;
  logic [1:0]    pkt_type;
  logic [1:0]    pkt_tid;
  logic          pkt_rdy;
  logic          thr_ack;
  logic          rstint;
  logic          nukeint;
  logic          resumint;
  logic [3:0]    rstthr;
  logic [AW:0]   fifo_cnt;
  logic          ovfl;
  logic          ovfl_clr;

  int tests = 0;
  int fails = 0;

  // Reference model state: queued packets {type,tid}, presented packet, sticky flag
  logic [3:0] mq[$];
  bit         m_pv;
  logic [3:0] m_pres;
  bit         m_ovfl;

  rstint_dispatch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .pkt_vld(pkt_vld), .pkt_type(pkt_type), .pkt_tid(pkt_tid),
    .pkt_rdy(pkt_rdy), .thr_ack(thr_ack), .rstint(rstint), .nukeint(nukeint),
    .resumint(resumint), .rstthr(rstthr), .fifo_cnt(fifo_cnt), .ovfl(ovfl), .ovfl_clr(ovfl_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_dup(input logic [3:0] p);
    bit d = 0;
`ifdef RSTINT_COALESCE_EN
    if (m_pv && m_pres == p) d = 1;
    foreach (mq[i]) if (mq[i] == p) d = 1;
`endif
    return d;
  endfunction

  // One clock cycle: drive inputs, check pkt_rdy, clock, advance model, check outputs
  task automatic step(input logic rst, input logic v, input logic [1:0] ty, input logic [1:0] td,
                      input logic ack, input logic clr);
    bit         avail, real_pkt, dupl, rdy;
    logic [3:0] p;
    reset = rst; pkt_vld = v; pkt_type = ty; pkt_tid = td; thr_ack = ack; ovfl_clr = clr;
    p        = {ty, td};
    avail    = !m_pv || ack;
    rdy      = (mq.size() < DEPTH) || (avail && mq.size() > 0);
    real_pkt = v && (ty != 2'b00);
    dupl     = real_pkt && m_is_dup(p);
    #1;
    chk("pkt_rdy", {31'd0, pkt_rdy}, {31'd0, rdy});
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_pv   = 0;
      m_ovfl = 0;
    end else begin
      if (real_pkt && !dupl && !rdy) m_ovfl = 1;
      else if (clr) m_ovfl = 0;
      if (real_pkt && !dupl && rdy) mq.push_back(p);
      if (avail) begin
        if (mq.size() > 0) begin
          m_pres = mq.pop_front();
          m_pv   = 1;
        end else begin
          m_pv = 0;
        end
      end
    end
    #1;
    chk("rstint",   {31'd0, rstint},   {31'd0, m_pv && m_pres[3:2] == 2'b01});
    chk("nukeint",  {31'd0, nukeint},  {31'd0, m_pv && m_pres[3:2] == 2'b10});
    chk("resumint", {31'd0, resumint}, {31'd0, m_pv && m_pres[3:2] == 2'b11});
    chk("rstthr",   {28'd0, rstthr},   m_pv ? (32'd1 << m_pres[1:0]) : 32'd0);
    chk("fifo_cnt", {29'd0, fifo_cnt}, mq.size());
    chk("ovfl",     {31'd0, ovfl},     {31'd0, m_ovfl});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 2'b00, ack, 0);
  endtask

  initial begin
    reset = 1; pkt_vld = 0; pkt_type = 0; pkt_tid = 0; thr_ack = 0; ovfl_clr = 0;
    m_pv = 0; m_pres = 0; m_ovfl = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 2'b00, 2'b00, 0, 0);
    chk("rst_rdy", {31'd0, pkt_rdy}, 32'd1);
    chk("rst_cnt", {29'd0, fifo_cnt}, 32'd0);

    // Single nuke tid2, held until ack, then outputs drop
    idle(7, 0);
    step(0, 1, 2'b10, 2'd2, 0, 0);
    chk("t1_nuke", {31'd0, nukeint}, 32'd1);
    chk("t1_thr", {28'd0, rstthr}, 32'h4);
    idle(3, 0);
    chk("t1_hold", {28'd0, rstthr}, 32'h4);
    idle(1, 1);
    chk("t1_off", {31'd0, nukeint}, 32'd0);
    chk("t1_thr_off", {28'd0, rstthr}, 32'h0);

    // Fill FIFO with ack held low, overflow on the 6th, then clear
    step(0, 1, 2'b01, 2'd0, 0, 0);
    step(0, 1, 2'b10, 2'd0, 0, 0);
    step(0, 1, 2'b11, 2'd0, 0, 0);
    step(0, 1, 2'b01, 2'd1, 0, 0);
    step(0, 1, 2'b10, 2'd1, 0, 0);
    chk("t2_full", {29'd0, fifo_cnt}, 32'd4);
    step(0, 1, 2'b11, 2'd1, 0, 0);
    chk("t2_ovfl", {31'd0, ovfl}, 32'd1);
    step(0, 0, 2'b00, 2'd0, 0, 1);
    chk("t2_clr", {31'd0, ovfl}, 32'd0);

    // Full FIFO, ack plus enqueue in the same cycle
    step(0, 1, 2'b01, 2'd2, 1, 0);
    chk("t3_cnt", {29'd0, fifo_cnt}, 32'd4);
    chk("t3_ovfl", {31'd0, ovfl}, 32'd0);
    idle(6, 1);

    // Strict order, consecutive presentation under continuous ack
    step(1, 0, 2'b00, 2'd0, 0, 0);
    step(0, 1, 2'b01, 2'd0, 1, 0);
    chk("t4_a", {31'd0, rstint}, 32'd1);
    step(0, 1, 2'b11, 2'd3, 1, 0);
    chk("t4_b", {28'd0, rstthr}, 32'h8);
    step(0, 1, 2'b10, 2'd1, 1, 0);
    chk("t4_c", {31'd0, nukeint}, 32'd1);
    idle(2, 1);

    // Reset while presenting with two queued
    step(0, 1, 2'b01, 2'd3, 0, 0);
    step(0, 1, 2'b10, 2'd3, 0, 0);
    step(0, 1, 2'b11, 2'd3, 0, 0);
    step(1, 0, 2'b00, 2'd0, 0, 0);
    chk("t5_cnt", {29'd0, fifo_cnt}, 32'd0);
    chk("t5_out", {28'd0, rstthr}, 32'h0);
    idle(2, 1);
    chk("t5_after", {31'd0, rstint | nukeint | resumint}, 32'd0);

    // Duplicate of the presented packet
    step(0, 1, 2'b10, 2'd1, 0, 0);
    step(0, 1, 2'b10, 2'd1, 0, 0);
`ifdef RSTINT_COALESCE_EN
    chk("t6_cnt", {29'd0, fifo_cnt}, 32'd0);
`else
    chk("t6_cnt", {29'd0, fifo_cnt}, 32'd1);
`endif
    idle(1, 1);
`ifdef RSTINT_COALESCE_EN
    chk("t6_re", {31'd0, nukeint}, 32'd0);
`else
    chk("t6_re", {31'd0, nukeint}, 32'd1);
`endif
    idle(2, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 60,
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
